cla_seq_ctrl: RTL
=================

Name: cla_seq_ctrl

Overview:
Sequencing controller that builds a wide add/subtract from one shared 4-bit carry look-ahead adder (dutcla_4b). Operands are processed one nibble per clock, least-significant first, with the carry held in a register between nibbles. A valid/ready handshake sits on both the operand side and the result side. The block is the arithmetic front-end for wider datapaths that cannot afford a full-width CLA.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand and result width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request
in_ready  output  1  controller idle, can accept operands
a  input  W  operand A
b  input  W  operand B
op  input  1  0 = add, 1 = subtract (A - B)
cin  input  1  carry-in for add; ignored for subtract
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  W  sum or difference
cout  output  1  final carry; for subtract, 1 = no borrow
ovf  output  1  two's-complement overflow
zero  output  1  result == 0

Behaviour:
- Clocking and reset (already decided): one clock, clk. reset_n is asynchronous and active-low; on assertion all state clears immediately, with no wait for clk.
- Reset values:
  - state = IDLE; nibble index = 0; carry register = 0.
  - in_ready = 1; out_valid = 0.
  - result, cout, ovf, zero = 0.
- in_ready = (state == IDLE), decoded combinationally from state.
- out_valid = (state == DONE), decoded combinationally from state.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - Accept on a rising edge with in_valid && in_ready.
  - Latch a, op, and b_eff = op ? ~b : b.
  - Carry register <= op ? 1 : cin. Index <= 0. Clear result.
  - Next state: ADD.
- ADD, one nibble per cycle:
  - Adder inputs: nibble[idx] of a, nibble[idx] of b_eff, and the carry register.
  - On the edge: result nibble[idx] <= sum; carry register <= adder cout; idx <= idx + 1.
  - When idx == NIBBLES-1, go to DONE on the same edge.
- Latency: out_valid rises exactly NIBBLES rising edges after the accept edge. With NIBBLES = 1 this is a single ADD cycle.
- DONE:
  - result, cout, ovf and zero are stable and must not change while out_valid = 1.
  - cout = final carry register.
  - ovf = (a[W-1] == b_eff[W-1]) && (result[W-1] != a[W-1]).
  - zero = (result == 0).
  - On an edge with out_ready = 1, go to IDLE; in_ready is 1 in the following cycle.
- No overlap: in_valid is ignored in ADD and DONE, and operands are never latched then. There is no same-cycle turnaround from DONE to accept.
- out_ready outside DONE has no effect.
- Input operand ports may change freely after the accept edge; only the latched copies are used.
- Reset mid-operation: the operation is aborted and the partial result discarded, with no out_valid pulse. After release the block is in IDLE with in_ready = 1.
- Wrap-around: add and subtract are modulo 2^W; the carry or borrow is reported only on cout.

Decomposition:
- Package cla_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  - localparam NIBBLE_W = 4;
  - typedef enum logic {OP_ADD, OP_SUB} op_t.
- One sub-module instance: dutcla_4b, the shared adder slice (ain, bin, cin -> sum, cout). It stays purely combinational; all registers live in cla_seq_ctrl.
- Nibble index width is $clog2(NIBBLES), minimum 1.

Test Plan:
1. NIBBLES=4: add a=0x1234, b=0x4321, cin=0 -> result 0x5555, cout=0, ovf=0, zero=0; out_valid rises on the 4th edge after accept.
2. Add a=0xFFFF, b=0x0001, cin=0 -> result 0x0000, cout=1, zero=1, ovf=0; checks carry ripple through every nibble register.
3. Subtract a=0x0005, b=0x0007 -> result 0xFFFE, cout=0 (borrow), ovf=0. Subtract 0x0007-0x0005 -> 0x0002, cout=1.
4. Add a=0x7FFF, b=0x0001 -> 0x8000, ovf=1, cout=0. Subtract 0x8000-0x0001 -> 0x7FFF, ovf=1.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> result/flags stable, in_ready=0, nothing latched. Raise out_ready -> IDLE next edge, in_ready=1, then the new operands are accepted.
6. Assert reset_n=0 between clock edges during the 2nd ADD cycle -> in_ready=1, out_valid=0, result=0 immediately. After release, a fresh add 0x0001+0x0001 gives 0x0002 with no leftover carry.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared types for the nibble-serial CLA add/subtract controller.
// Holds FSM state encoding, operation codes and slice width.
package cla_seq_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    typedef enum logic {OP_ADD, OP_SUB} op_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/cla_seq_ctrl_dutcla_4b.sv
// Purely combinational 4-bit carry look-ahead adder slice.
// Shared by every nibble step of the sequencing controller.
module dutcla_4b
    import cla_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] ain,
    input  logic [NIBBLE_W-1:0] bin,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // Generate/propagate terms and flattened look-ahead carries.
    always_comb begin
        g    = ain & bin;
        p    = ain ^ bin;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
    end

endmodule

// File: rtl/cla_seq_ctrl.sv
// Wide add/subtract built from one shared 4-bit CLA slice,
// one nibble per clock, LSB first, valid/ready on both sides.
module cla_seq_ctrl
    import cla_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      op,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] result,
    output logic                      cout,
    output logic                      ovf,
    output logic                      zero
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t                state;
    logic [IW-1:0]         idx;
    logic                  carry;
    logic [W-1:0]          a_r;
    logic [W-1:0]          b_r;

    logic [NIBBLE_W-1:0]   a_nib;
    logic [NIBBLE_W-1:0]   b_nib;
    logic [NIBBLE_W-1:0]   s_nib;
    logic                  s_cout;
    logic [W-1:0]          res_next;
    logic                  last;
    logic                  is_sub;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign is_sub    = (op_t'(op) == OP_SUB);
    assign last      = (idx == IW'(NIBBLES - 1));

    // Select the current nibble and splice the new sum into the result.
    always_comb begin
        a_nib    = a_r[NIBBLE_W*int'(idx) +: NIBBLE_W];
        b_nib    = b_r[NIBBLE_W*int'(idx) +: NIBBLE_W];
        res_next = result;
        res_next[NIBBLE_W*int'(idx) +: NIBBLE_W] = s_nib;
    end

    dutcla_4b u_cla (
        .ain  (a_nib),
        .bin  (b_nib),
        .cin  (carry),
        .sum  (s_nib),
        .cout (s_cout)
    );

    // Sequencer: accept, step one nibble per cycle, hold until drained.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= is_sub ? ~b : b;
                        carry  <= is_sub ? 1'b1 : cin;
                        idx    <= '0;
                        result <= '0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    result <= res_next;
                    carry  <= s_cout;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        state <= DONE;
                        cout  <= s_cout;
                        zero  <= (res_next == '0);
                        ovf   <= (a_r[W-1] == b_r[W-1])
                              && (res_next[W-1] != a_r[W-1]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
